matrix3_stream_sequencer: RTL and testbench
===========================================

// Module: matrix3_stream_sequencer
// PURPOSE
//  Pixel-stream front end and scheduler for the 3x3 colorspace datapath. Runs on I_CLK.
//  Samples the slow VGA pixel domain by detecting I_PIXEL_CLK rising edges.
//  Counts columns/rows, rotates three line-buffer write selects and drives buffer write strobes.
//  Tells the converter/matrix stage when a full 3x3 window exists and which centre pixel it is.
// PARAMETERS
//  P_FRAME_COLUMNS  640  active pixels per line (>=3)
//  P_FRAME_ROWS     480  active lines per frame (>=3)
//  P_PIXEL_DEPTH    24   bits per RGB pixel
// PORTS
//  I_CLK                 in   1      system clock, ~333 MHz
//  I_RESET               in   1      synchronous, active-high reset
//  I_ENABLE              in   1      0: pixel strobes ignored, all state held
//  I_PIXEL_CLK           in   1      async pixel clock, ~25.175 MHz; 2-flop synchronised internally
//  I_DATA_VALID          in   1      active-video qualifier (pixel-clock domain)
//  I_PIXEL               in   DEPTH  RGB pixel (pixel-clock domain)
//  O_BUF_WR_EN           out  1      1-cycle line-buffer write strobe
//  O_BUF_WR_SEL          out  2      target line buffer; values 0,1,2 only
//  O_BUF_ADDR            out  COLB   write address = current column
//  O_BUF_DATA            out  DEPTH  pixel to write
//  O_PIXEL_COLUMN        out  COLB   window centre column ($clog2(P_FRAME_COLUMNS) bits)
//  O_PIXEL_ROW           out  ROWB   window centre row ($clog2(P_FRAME_ROWS) bits)
//  O_PIXEL_MATRIX_READY  out  1      1-cycle pulse: 3x3 window complete
//  O_FRAME_DONE          out  1      1-cycle pulse after the last pixel of a frame
// BEHAVIOUR
//  - Reset: state S_IDLE. Column, row, WR_SEL, ADDR, DATA and COLUMN/ROW = 0; every strobe output = 0.
//  - Edge strobe: synchroniser plus a registered rising-edge detect produce one I_CLK pulse per pixel-clock edge.
//  - On that pulse, I_DATA_VALID and I_PIXEL are sampled through the same synchroniser depth.
//  - Latency: edge pulse at cycle E. Cycle E+1: WR_EN=1 with ADDR=column, DATA=pixel, SEL=current.
//  - Cycle E+2: READY pulse, if the window is eligible.
//  - Edge pulse with valid=0 is blanking: no write; column, row and SEL are held.
//  - Counters: column increments per valid pixel and wraps P_FRAME_COLUMNS-1 -> 0.
//  - On column wrap: row increments and SEL rotates 0->1->2->0.
//  - Last pixel (row ROWS-1, column COLS-1): row, column and SEL return to 0, O_FRAME_DONE pulses at E+2, state -> S_IDLE.
//  - FSM:
//    - S_IDLE -> S_FILL on the first valid pixel.
//    - S_FILL (rows 0-1) -> S_STREAM at the wrap into row 2.
//    - S_STREAM -> S_IDLE after the last pixel.
//  - READY is asserted only in S_STREAM with column >= 2.
//  - With READY: O_PIXEL_COLUMN = written column-1, O_PIXEL_ROW = written row-1, both held until the next READY.
//  - Per frame: exactly (COLS-2)*(ROWS-2) READY pulses; no edge-of-frame windows.
//  - I_ENABLE=0: strobes are dropped and nothing advances.
//  - If an edge pulse coincides with I_ENABLE falling, that pulse is dropped.
//  - Reset mid-frame returns to S_IDLE on the next edge. Pending WR_EN/READY are cancelled.
// CONFIGURATION
//  SEQUENCER_LINE_CHECK_EN
//  - Defined: adds output O_LINE_ERROR (1).
//    - If valid falls while column != 0 (short line), O_LINE_ERROR pulses at E+2 and the line is resynchronised.
//    - Resync: column -> 0, row increments, SEL rotates, FSM follows the same row rules.
//    - O_LINE_ERROR resets to 0.
//  - Undefined: no O_LINE_ERROR port. Mid-line valid gaps are a stall and the counters hold.
// STRUCTURE
//  - Package matrix3_sequencer_pkg:
//    - state enum {S_IDLE,S_FILL,S_STREAM}
//    - typedef buf_sel_t (logic [1:0])
//    - constant C_SYNC_STAGES=2
//  - Sub-module pixel_clock_edge_detector: sync chain + rising-edge pulse for I_PIXEL_CLK, valid and pixel.
//  - Counters, FSM and output registers stay in the top.
// TESTING
//  - Params: COLS=8, ROWS=4, DEPTH=24; pixel clock 79.444 ns vs 6 ns I_CLK.
//  - T1 reset: hold I_RESET 2 cycles -> all outputs 0, SEL=0, no strobes while pixel clock toggles with valid=0.
//  - T2 full frame: 32 valid pixels (pixel=index) -> 32 WR_EN, ADDR 0..7 repeating, DATA=index.
//    - Expect 12 READY pulses; first with COLUMN=1, ROW=1; last with COLUMN=6, ROW=2.
//    - Expect one FRAME_DONE.
//  - T3 rotation: 4 lines -> SEL 0,1,2,0 per line; next frame starts with SEL=0.
//  - T4 gap: valid=0 for 3 edges after column 4 of row 2.
//    - Macro off: no writes, next write ADDR=5.
//    - Macro on: O_LINE_ERROR pulse, next write ADDR=0 with SEL advanced.
//  - T5 reset mid-frame: assert I_RESET at row 2, column 3 -> no further WR_EN/READY.
//    - New frame restarts at ADDR=0, SEL=0 and produces 12 READY.
//  - T6 enable: I_ENABLE=0 for 5 pixel edges in row 1 -> no writes, counters hold, resume at the held column.

Source files
------------

// File: rtl/matrix3_sequencer_pkg.sv
// Shared types and constants for the 3x3 colorspace pixel-stream sequencer.
`timescale 1ns/1ps
package matrix3_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STREAM
  } state_t;

  typedef logic [1:0] buf_sel_t;

  localparam int C_SYNC_STAGES = 2;

endpackage

// File: rtl/pixel_clock_edge_detector.sv
// Synchronises the pixel clock, valid qualifier and pixel bus into the system
// clock domain and emits a one-cycle strobe per pixel-clock rising edge.
`timescale 1ns/1ps
module pixel_clock_edge_detector
  import matrix3_sequencer_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_clk,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] pixel,
  output logic              strobe,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  localparam int LAST = C_SYNC_STAGES - 1;

  logic [C_SYNC_STAGES-1:0] clk_sync_p0;
  logic [C_SYNC_STAGES-1:0] vld_sync_p0;
  logic [DATA_W-1:0]        pix_sync_p0 [C_SYNC_STAGES];
  logic                     clk_prev_p1;

  // Sync chains and edge history keep tracking through reset, so releasing
  // reset while the pixel clock is high cannot fabricate an edge.
  always_ff @(posedge clk) begin
    clk_sync_p0    <= {clk_sync_p0[C_SYNC_STAGES-2:0], pixel_clk};
    vld_sync_p0    <= {vld_sync_p0[C_SYNC_STAGES-2:0], data_valid};
    pix_sync_p0[0] <= pixel;
    for (int i = 1; i < C_SYNC_STAGES; i++) begin
      pix_sync_p0[i] <= pix_sync_p0[i-1];
    end
    clk_prev_p1 <= clk_sync_p0[LAST];
    valid       <= vld_sync_p0[LAST];
    data        <= pix_sync_p0[LAST];
  end

  // ---- stage p1: rising-edge strobe, aligned with valid/data ----
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe <= 1'b0;
    end else begin
      strobe <= clk_sync_p0[LAST] & ~clk_prev_p1;
    end
  end

endmodule

// File: rtl/matrix3_stream_sequencer.sv
// Pixel-stream front end / scheduler for the 3x3 colorspace datapath.
// Optional short-line detection and resync: define SEQUENCER_LINE_CHECK_EN.
`timescale 1ns/1ps
module matrix3_stream_sequencer
  import matrix3_sequencer_pkg::*;
#(
  parameter int  P_FRAME_COLUMNS = 640,
  parameter int  P_FRAME_ROWS    = 480,
  parameter int  P_PIXEL_DEPTH   = 24,
  localparam int COLB = $clog2(P_FRAME_COLUMNS),
  localparam int ROWB = $clog2(P_FRAME_ROWS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     pixel_clk,
  input  logic                     data_valid,
  input  logic [P_PIXEL_DEPTH-1:0] pixel,
  output logic                     buf_wr_en,
  output buf_sel_t                 buf_wr_sel,
  output logic [COLB-1:0]          buf_addr,
  output logic [P_PIXEL_DEPTH-1:0] buf_data,
  output logic [COLB-1:0]          pixel_column,
  output logic [ROWB-1:0]          pixel_row,
  output logic                     pixel_matrix_ready,
  output logic                     frame_done
`ifdef SEQUENCER_LINE_CHECK_EN
  ,
  output logic                     line_error
`endif
);

  localparam logic [COLB-1:0] C_LAST_COL = COLB'(P_FRAME_COLUMNS - 1);
  localparam logic [ROWB-1:0] C_LAST_ROW = ROWB'(P_FRAME_ROWS - 1);

  function automatic buf_sel_t rotate_sel(input buf_sel_t s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  logic                     edge_p0;
  logic                     dv_p0;
  logic [P_PIXEL_DEPTH-1:0] pix_p0;

  pixel_clock_edge_detector #(
    .DATA_W (P_PIXEL_DEPTH)
  ) u_edge (
    .clk        (clk),
    .reset      (reset),
    .pixel_clk  (pixel_clk),
    .data_valid (data_valid),
    .pixel      (pixel),
    .strobe     (edge_p0),
    .valid      (dv_p0),
    .data       (pix_p0)
  );

  state_t          state;
  state_t          state_nxt;
  logic [COLB-1:0] column;
  logic [ROWB-1:0] row;
  buf_sel_t        sel;

  logic adv_pix;
  logic adv_gap;
  logic line_wrap;
  logic frame_end;
  logic win_ok;

  always_comb begin
    adv_pix = edge_p0 & enable & dv_p0;
`ifdef SEQUENCER_LINE_CHECK_EN
    adv_gap = edge_p0 & enable & ~dv_p0 & (column != '0);
`else
    adv_gap = 1'b0;
`endif
    line_wrap = (adv_pix & (column == C_LAST_COL)) | adv_gap;
    frame_end = line_wrap & (row == C_LAST_ROW);
    // Windows only exist once two full lines are buffered and two columns seen
    win_ok    = (state == S_STREAM) & (column >= COLB'(2));
  end

  always_comb begin
    state_nxt = state;
    if (adv_pix && state == S_IDLE) state_nxt = S_FILL;
    if (frame_end) begin
      state_nxt = S_IDLE;
    end else if (line_wrap && row == ROWB'(1)) begin
      state_nxt = S_STREAM;
    end
  end

  // ---- stage p0: counters and FSM, advanced on the edge strobe ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      column <= '0;
      row    <= '0;
      sel    <= '0;
    end else begin
      state <= state_nxt;
      if (frame_end) begin
        column <= '0;
        row    <= '0;
        sel    <= '0;
      end else if (line_wrap) begin
        column <= '0;
        row    <= row + ROWB'(1);
        sel    <= rotate_sel(sel);
      end else if (adv_pix) begin
        column <= column + COLB'(1);
      end
    end
  end

  logic                     vld_p1;
  buf_sel_t                 sel_p1;
  logic [COLB-1:0]          addr_p1;
  logic [P_PIXEL_DEPTH-1:0] data_p1;
  logic                     win_p1;
  logic                     done_p1;
  logic [COLB-1:0]          win_col_p1;
  logic [ROWB-1:0]          win_row_p1;

  // ---- stage p1: line-buffer write ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      win_p1  <= 1'b0;
      done_p1 <= 1'b0;
      sel_p1  <= '0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= adv_pix;
      win_p1  <= adv_pix & win_ok;
      done_p1 <= adv_pix & frame_end;
      if (adv_pix) begin
        sel_p1  <= sel;
        addr_p1 <= column;
        data_p1 <= pix_p0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv_pix) begin
      win_col_p1 <= column - COLB'(1);
      win_row_p1 <= row - ROWB'(1);
    end
  end

  logic            ready_p2;
  logic            done_p2;
  logic [COLB-1:0] col_p2;
  logic [ROWB-1:0] row_p2;

  // ---- stage p2: window-ready and frame-done pulses ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_p2 <= 1'b0;
      done_p2  <= 1'b0;
      col_p2   <= '0;
      row_p2   <= '0;
    end else begin
      ready_p2 <= win_p1;
      done_p2  <= done_p1;
      if (win_p1) begin
        col_p2 <= win_col_p1;
        row_p2 <= win_row_p1;
      end
    end
  end

`ifdef SEQUENCER_LINE_CHECK_EN
  logic lerr_p1;
  logic lerr_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      lerr_p1 <= 1'b0;
      lerr_p2 <= 1'b0;
    end else begin
      lerr_p1 <= adv_gap;
      lerr_p2 <= lerr_p1;
    end
  end

  assign line_error = lerr_p2;
`endif

  assign buf_wr_en          = vld_p1;
  assign buf_wr_sel         = sel_p1;
  assign buf_addr           = addr_p1;
  assign buf_data           = data_p1;
  assign pixel_column       = col_p2;
  assign pixel_row          = row_p2;
  assign pixel_matrix_ready = ready_p2;
  assign frame_done         = done_p2;

endmodule

// File: tb/tb_matrix3_stream_sequencer.sv
// Directed self-checking bench for matrix3_stream_sequencer (8x4 frame, 24-bit pixels).
`timescale 1ns/1ps
module tb_matrix3_stream_sequencer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        pixel_clk;
  logic        data_valid;
  logic [23:0] pixel;
  logic        buf_wr_en;
  logic [1:0]  buf_wr_sel;
  logic [2:0]  buf_addr;
  logic [23:0] buf_data;
  logic [2:0]  pixel_column;
  logic [1:0]  pixel_row;
  logic        pixel_matrix_ready;
  logic        frame_done;
`ifdef SEQUENCER_LINE_CHECK_EN
  logic        line_error;
`endif

  matrix3_stream_sequencer #(
    .P_FRAME_COLUMNS (8),
    .P_FRAME_ROWS    (4),
    .P_PIXEL_DEPTH   (24)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .pixel_clk          (pixel_clk),
    .data_valid         (data_valid),
    .pixel              (pixel),
    .buf_wr_en          (buf_wr_en),
    .buf_wr_sel         (buf_wr_sel),
    .buf_addr           (buf_addr),
    .buf_data           (buf_data),
    .pixel_column       (pixel_column),
    .pixel_row          (pixel_row),
    .pixel_matrix_ready (pixel_matrix_ready),
    .frame_done         (frame_done)
`ifdef SEQUENCER_LINE_CHECK_EN
    ,
    .line_error         (line_error)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #3 clk = ~clk;
  end

  initial begin
    pixel_clk = 1'b0;
    forever #39.722 pixel_clk = ~pixel_clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  int wr_addr_q[$];
  int wr_sel_q[$];
  int wr_data_q[$];
  int rdy_col_q[$];
  int rdy_row_q[$];
  int done_cnt = 0;
  int lerr_cnt = 0;

  always @(negedge clk) begin
    if (buf_wr_en === 1'b1) begin
      wr_addr_q.push_back(int'(buf_addr));
      wr_sel_q.push_back(int'(buf_wr_sel));
      wr_data_q.push_back(int'(buf_data));
    end
    if (pixel_matrix_ready === 1'b1) begin
      rdy_col_q.push_back(int'(pixel_column));
      rdy_row_q.push_back(int'(pixel_row));
    end
    if (frame_done === 1'b1) done_cnt++;
`ifdef SEQUENCER_LINE_CHECK_EN
    if (line_error === 1'b1) lerr_cnt++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_sel_q.delete();
    wr_data_q.delete();
    rdy_col_q.delete();
    rdy_row_q.delete();
    done_cnt = 0;
    lerr_cnt = 0;
  endtask

  // Presents one pixel-domain sample, changed mid-period so it is stable at the rising edge.
  task automatic send(input logic v, input logic [23:0] p, input logic en);
    @(negedge pixel_clk);
    data_valid = v;
    pixel      = p;
    enable     = en;
  endtask

  task automatic flush();
    repeat (3) send(1'b0, 24'd0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    data_valid = 1'b0;
    pixel      = 24'd0;

    // T1: reset state, then blanking edges produce nothing
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", buf_wr_en, 0);
    chk("rst_sel", buf_wr_sel, 0);
    chk("rst_addr", buf_addr, 0);
    chk("rst_data", buf_data, 0);
    chk("rst_col", pixel_column, 0);
    chk("rst_row", pixel_row, 0);
    chk("rst_ready", pixel_matrix_ready, 0);
    chk("rst_done", frame_done, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) send(1'b0, 24'd0, 1'b1);
    flush();
    chk("t1_writes", wr_addr_q.size(), 0);
    chk("t1_ready", rdy_col_q.size(), 0);
    chk("t1_done", done_cnt, 0);

    // T2/T3: one full frame, pixel value = index
    clear_log();
    for (int i = 0; i < 32; i++) send(1'b1, 24'(i), 1'b1);
    flush();
    chk("t2_writes", wr_addr_q.size(), 32);
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      chk($sformatf("t2_addr[%0d]", i), wr_addr_q[i], i % 8);
      chk($sformatf("t2_data[%0d]", i), wr_data_q[i], i);
      chk($sformatf("t3_sel[%0d]", i), wr_sel_q[i], (i / 8) % 3);
    end
    chk("t2_ready_cnt", rdy_col_q.size(), 12);
    for (int k = 0; k < rdy_col_q.size(); k++) begin
      chk($sformatf("t2_rdy_col[%0d]", k), rdy_col_q[k], 1 + k % 6);
      chk($sformatf("t2_rdy_row[%0d]", k), rdy_row_q[k], 1 + k / 6);
    end
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_col_held", pixel_column, 6);
    chk("t2_row_held", pixel_row, 2);

    // T4: three blanking edges after column 4 of row 2
    clear_log();
    for (int i = 0; i < 21; i++) send(1'b1, 24'(i), 1'b1);
    repeat (3) send(1'b0, 24'd0, 1'b1);
    chk("t3_next_frame_sel", wr_sel_q[0], 0);
    chk("t4_gap_writes", wr_addr_q.size(), 21);
`ifdef SEQUENCER_LINE_CHECK_EN
    chk("t4_line_error", lerr_cnt, 1);
    for (int i = 24; i < 32; i++) send(1'b1, 24'(i), 1'b1);
    flush();
    chk("t4_resume_addr", wr_addr_q[21], 0);
    chk("t4_resume_sel", wr_sel_q[21], 0);
    chk("t4_resume_data", wr_data_q[21], 24);
    chk("t4_writes", wr_addr_q.size(), 29);
    chk("t4_ready_cnt", rdy_col_q.size(), 9);
    chk("t4_done_cnt", done_cnt, 1);
`else
    for (int i = 21; i < 32; i++) send(1'b1, 24'(i), 1'b1);
    flush();
    chk("t4_resume_addr", wr_addr_q[21], 5);
    chk("t4_resume_sel", wr_sel_q[21], 2);
    chk("t4_resume_data", wr_data_q[21], 21);
    chk("t4_writes", wr_addr_q.size(), 32);
    chk("t4_ready_cnt", rdy_col_q.size(), 12);
    chk("t4_done_cnt", done_cnt, 1);
`endif

    // T5: reset while row 2 column 3 is in flight
    clear_log();
    for (int i = 0; i < 19; i++) send(1'b1, 24'(i), 1'b1);
    send(1'b1, 24'd19, 1'b1);
    @(posedge pixel_clk);
    #3;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t5_rst_wr_en", buf_wr_en, 0);
    chk("t5_rst_addr", buf_addr, 0);
    chk("t5_rst_ready", pixel_matrix_ready, 0);
    chk("t5_rst_col", pixel_column, 0);
    @(negedge clk);
    reset = 1'b0;
    flush();
    chk("t5_writes_frozen", wr_addr_q.size(), 19);
    chk("t5_ready_frozen", rdy_col_q.size(), 1);
    clear_log();
    for (int i = 0; i < 32; i++) send(1'b1, 24'(i + 64), 1'b1);
    flush();
    chk("t5_new_addr", wr_addr_q[0], 0);
    chk("t5_new_sel", wr_sel_q[0], 0);
    chk("t5_new_data", wr_data_q[0], 64);
    chk("t5_writes", wr_addr_q.size(), 32);
    chk("t5_ready_cnt", rdy_col_q.size(), 12);
    chk("t5_done_cnt", done_cnt, 1);

    // T6: enable low for five valid edges in row 1
    clear_log();
    for (int i = 0; i < 11; i++) send(1'b1, 24'(i), 1'b1);
    for (int j = 0; j < 5; j++) send(1'b1, 24'(500 + j), 1'b0);
    send(1'b1, 24'd11, 1'b1);
    chk("t6_disabled_writes", wr_addr_q.size(), 11);
    for (int i = 12; i < 32; i++) send(1'b1, 24'(i), 1'b1);
    flush();
    chk("t6_resume_addr", wr_addr_q[11], 3);
    chk("t6_resume_sel", wr_sel_q[11], 1);
    chk("t6_resume_data", wr_data_q[11], 11);
    chk("t6_writes", wr_addr_q.size(), 32);
    chk("t6_ready_cnt", rdy_col_q.size(), 12);
    chk("t6_done_cnt", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
